// File: rtl/edge_event_decoder.sv
// Edge event decoder: turns rise/fall/change pulses from an edge detector
// into a reconstructed level, saturating edge counts and captured event data.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   enable              1 = process events, 0 = hold everything
//   clear_err           leave ERROR and return to UNKNOWN
//   posedge_detection   rising-edge event pulse
//   negedge_detection   falling-edge event pulse
//   change_detection    any-edge event pulse
//   data_in             data word tied to the event cycle
//   level_out           reconstructed level (1 only in HIGH)
//   level_valid         level_out is known (LOW or HIGH)
//   err, err_code       sticky error flag; 01 illegal combo, 10 sequence
//   rise_count          accepted rising events, saturating
//   fall_count          accepted falling events, saturating
//   data_out            data_in captured on the last accepted event
//   data_valid          one-cycle pulse marking a new data_out
module edge_event_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clear_err,
    input  logic        posedge_detection,
    input  logic        negedge_detection,
    input  logic        change_detection,
    input  logic [31:0] data_in,
    output logic        level_out,
    output logic        level_valid,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] rise_count,
    output logic [15:0] fall_count,
    output logic [31:0] data_out,
    output logic        data_valid
);

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_LOW     = 2'd1,
        ST_HIGH    = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_ILL  = 2'b01;
    localparam logic [1:0] CODE_SEQ  = 2'b10;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    state_t      state_q, state_nxt;
    logic [1:0]  code_q, code_nxt;
    logic [15:0] rise_q, rise_nxt;
    logic [15:0] fall_q, fall_nxt;
    logic [31:0] data_q, data_nxt;
    logic        dv_q, dv_nxt;
    logic        level_q, lvalid_q, err_q;

    logic ev_idle, ev_rise, ev_fall, ev_ill;
    logic acc_rise, acc_fall;

    // Only three (pos,neg,chg) patterns are meaningful; anything else
    // means the upstream detector is inconsistent.
    assign ev_idle = ~posedge_detection & ~negedge_detection & ~change_detection;
    assign ev_rise =  posedge_detection & ~negedge_detection &  change_detection;
    assign ev_fall = ~posedge_detection &  negedge_detection &  change_detection;
    assign ev_ill  = ~(ev_idle | ev_rise | ev_fall);

    always_comb begin
        state_nxt = state_q;
        code_nxt  = code_q;
        acc_rise  = 1'b0;
        acc_fall  = 1'b0;
        if (enable) begin
            if (state_q == ST_ERROR) begin
                // Sticky: only clear_err gets out; events are dropped.
                if (clear_err) begin
                    state_nxt = ST_UNKNOWN;
                    code_nxt  = CODE_NONE;
                end
            end else if (ev_ill) begin
                state_nxt = ST_ERROR;
                code_nxt  = CODE_ILL;
            end else if (ev_rise) begin
                if (state_q == ST_HIGH) begin
                    state_nxt = ST_ERROR;
                    code_nxt  = CODE_SEQ;
                end else begin
                    state_nxt = ST_HIGH;
                    acc_rise  = 1'b1;
                end
            end else if (ev_fall) begin
                if (state_q == ST_LOW) begin
                    state_nxt = ST_ERROR;
                    code_nxt  = CODE_SEQ;
                end else begin
                    state_nxt = ST_LOW;
                    acc_fall  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rise_nxt = rise_q;
        fall_nxt = fall_q;
        data_nxt = data_q;
        dv_nxt   = 1'b0;
        if (acc_rise && rise_q != CNT_MAX) begin
            rise_nxt = rise_q + 16'd1;
        end
        if (acc_fall && fall_q != CNT_MAX) begin
            fall_nxt = fall_q + 16'd1;
        end
        if (acc_rise || acc_fall) begin
            data_nxt = data_in;
            dv_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_UNKNOWN;
            code_q   <= CODE_NONE;
            rise_q   <= '0;
            fall_q   <= '0;
            data_q   <= '0;
            dv_q     <= 1'b0;
            level_q  <= 1'b0;
            lvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            code_q   <= code_nxt;
            rise_q   <= rise_nxt;
            fall_q   <= fall_nxt;
            data_q   <= data_nxt;
            dv_q     <= dv_nxt;
            level_q  <= (state_nxt == ST_HIGH);
            lvalid_q <= (state_nxt == ST_HIGH) || (state_nxt == ST_LOW);
            err_q    <= (state_nxt == ST_ERROR);
        end
    end

    assign level_out   = level_q;
    assign level_valid = lvalid_q;
    assign err         = err_q;
    assign err_code    = code_q;
    assign rise_count  = rise_q;
    assign fall_count  = fall_q;
    assign data_out    = data_q;
    assign data_valid  = dv_q;

endmodule
